ssp_serial_rx: RTL and testbench
================================

# ssp_serial_rx

Receive-side deserializer and buffer for the SSP serial link. It consumes the frame-sync / serial-clock / data stream produced by an SSP transmitter, which is looped back onto SSPCLKIN/SSPFSSIN/SSPRXD. It assembles MSB-first 8-bit frames and queues them in a small FIFO. The processor bus drains the FIFO through the same PSEL/PWRITE read strobe the SSP uses.

## Interface
Parameters:
- DATA_W, 8, frame width in bits
- DEPTH, 4, FIFO entries (power of two)

Ports:
- PCLK  in  1  system clock; all logic on rising edge
- CLEAR_B  in  1  synchronous, active-low reset
- PSEL  in  1  bus select
- PWRITE  in  1  bus direction; a read strobe is PSEL=1 with PWRITE=0
- SSPCLKIN  in  1  serial clock, sampled as data by PCLK, at most PCLK/2
- SSPFSSIN  in  1  frame sync, high for one serial-clock period before bit 7
- SSPRXD  in  1  serial data; changes on serial-clock rise, valid on fall
- PRDATA  out  DATA_W  FIFO head entry; 0 when empty
- SSPRXINTR  out  1  FIFO full
- RXEMPTY  out  1  FIFO empty
- RXOVR  out  1  sticky overrun flag

## Operation
- Edge detect: register sclk_q <= SSPCLKIN. A falling edge (fe) is sclk_q=1 and SSPCLKIN=0 in the current cycle. SSPFSSIN and SSPRXD are sampled only in fe cycles.
- FSM states:
  - IDLE: on fe with SSPFSSIN=1, go to SHIFT with bitcnt=0.
  - SHIFT: each fe shifts SSPRXD into shreg (MSB first) and increments bitcnt.
  - Frame end: on the fe where bitcnt=DATA_W-1, push {shreg[DATA_W-2:0], SSPRXD} to the FIFO. Then go to SHIFT with bitcnt=0 if SSPFSSIN=1 in that same fe cycle (back-to-back frame), else to IDLE.
- SSPFSSIN=1 in SHIFT before the last bit is ignored; the frame is not restarted.
- FIFO push:
  - Not full: write at wr_ptr.
  - Full, no pop in the same cycle: drop the byte, set RXOVR, leave contents unchanged.
  - Full with a pop in the same cycle: both proceed, count unchanged, no overrun.
- FIFO pop: a read strobe while not empty advances rd_ptr. A strobe while empty is ignored, with no underflow state. Write strobes (PSEL=1, PWRITE=1) have no effect.
- RXOVR clears on the first successful pop after it was set; set takes priority if both occur in the same cycle.
- Pointers are log2(DEPTH)+1 bits. Full when the MSBs differ and the LSBs are equal; empty when equal. Wrap is natural modulo 2·DEPTH.
- Reset (CLEAR_B=0 at a PCLK edge), including mid-frame:
  - State to IDLE; bitcnt, shreg and sclk_q cleared.
  - FIFO emptied; the partial frame is discarded.
  - Outputs: PRDATA=0, SSPRXINTR=0, RXEMPTY=1, RXOVR=0.

## Timing
- Final bit is sampled at PCLK edge E, and the push also occurs at E. After E, RXEMPTY falls, PRDATA shows the byte (if it is the head), and SSPRXINTR reflects the new count. Push latency is zero cycles after the sampling edge.
- PRDATA is combinational from the head register. A pop at edge E shows the next entry (or 0) after E.
- With SSPCLKIN=PCLK/2, one frame is 2·DATA_W PCLK cycles after the FSS bit. Back-to-back frames sustain one byte per 16 PCLK.
- Minimum SSPCLKIN high and low time is one PCLK cycle. A fe cannot occur on two consecutive cycles.

## Structure
- Package ssp_pkg holds:
  - DATA_W and DEPTH defaults
  - the rx FSM state encoding (IDLE, SHIFT)
  - the pointer-width function
- Sub-module ssp_rx_fifo holds storage, pointers, full/empty, and simultaneous push/pop handling.
- The top level holds edge detect, the FSM, the shifter and RXOVR.

## Test plan
- Single frame 0x35 (FSS pulse, then 8 bits at PCLK/2) -> after the last fe: RXEMPTY=0, PRDATA=0x35. One read strobe -> RXEMPTY=1, PRDATA=0.
- Back-to-back 0xAE then 0x26, with FSS high during the last bit of 0xAE -> FIFO holds 0xAE, 0x26 in order; no dropped bits.
- Four frames 0x39, 0x9D, 0x74, 0x8F with no reads -> SSPRXINTR=1 after the 4th. A 5th frame 0xB1 -> RXOVR=1, FIFO still 0x39..0x8F. A pop -> RXOVR=0, PRDATA=0x9D.
- FIFO full, with a read strobe in the same cycle as the 5th frame's last fe -> RXOVR stays 0; FIFO holds 0x9D, 0x74, 0x8F, 0xB1.
- CLEAR_B=0 after 4 bits of frame 0x55 and with 2 entries queued -> all outputs at reset values. A following full frame 0x55 is received correctly.
- Read strobe while empty, and write strobe with data present -> no state change; PRDATA unchanged.

Source files
------------

// File: rtl/ssp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ssp_pkg
//  Description : Shared defaults, receive FSM encoding and pointer sizing
//                for the SSP serial receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package ssp_pkg;

    // Default frame width in bits and FIFO depth (entries, power of two)
    localparam int c_data_w = 8;
    localparam int c_depth  = 4;

    // Receive FSM encoding
    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

    // FIFO pointers carry one extra wrap bit above the address bits
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssp_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ssp_rx_fifo
//  Description : Receive FIFO with wrap-bit pointers. A push into a full
//                FIFO is dropped unless a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ssp_rx_fifo
    import ssp_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int DEPTH  = c_depth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_drop,
    output logic              o_popped
);

    localparam int c_ptr_w  = ptr_width(DEPTH);
    localparam int c_addr_w = c_ptr_w - 1;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_addr_w-1:0] w_wr_addr;
    logic [c_addr_w-1:0] w_rd_addr;
    logic                w_do_push;
    logic                w_do_pop;

    assign w_wr_addr = r_wr_ptr[c_addr_w-1:0];
    assign w_rd_addr = r_rd_ptr[c_addr_w-1:0];

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                     (w_wr_addr == w_rd_addr);

    // A pop frees the head slot in the same cycle, so a full FIFO can accept
    // a simultaneous push; the write lands in the slot being vacated.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_drop    = i_push && o_full && !w_do_pop;
    assign o_popped  = w_do_pop;

    assign o_head = o_empty ? '0 : r_mem[w_rd_addr];

    // Pointer update; both pointers wrap naturally modulo 2*DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
        end
    end

    // Storage write; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_addr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ssp_serial_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ssp_serial_rx
//  Description : SSP receive deserializer. Detects serial-clock falling
//                edges, assembles MSB-first frames and queues them in a FIFO
//                drained by bus read strobes. Tracks a sticky overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module ssp_serial_rx
    import ssp_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int DEPTH  = c_depth
) (
    input  logic              PCLK,
    input  logic              CLEAR_B,
    input  logic              PSEL,
    input  logic              PWRITE,
    input  logic              SSPCLKIN,
    input  logic              SSPFSSIN,
    input  logic              SSPRXD,
    output logic [DATA_W-1:0] PRDATA,
    output logic              SSPRXINTR,
    output logic              RXEMPTY,
    output logic              RXOVR
);

    localparam int                 c_cnt_w    = $clog2(DATA_W);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_W - 1);

    logic                r_sclk_q;
    rx_state_t           r_state;
    rx_state_t           w_state_nxt;
    logic [c_cnt_w-1:0]  r_bitcnt;
    logic [c_cnt_w-1:0]  w_bitcnt_nxt;
    // Only the first DATA_W-1 bits need storing; the last bit goes straight
    // from SSPRXD into the FIFO.
    logic [DATA_W-2:0]   r_shreg;
    logic [DATA_W-2:0]   w_shreg_nxt;
    logic                w_fe;
    logic                w_push;
    logic [DATA_W-1:0]   w_push_data;
    logic                w_rd_strobe;
    logic                w_rst;
    logic                w_drop;
    logic                w_popped;
    logic                r_ovr;

    assign w_rst       = ~CLEAR_B;
    assign w_fe        = r_sclk_q && !SSPCLKIN;
    assign w_rd_strobe = PSEL && !PWRITE;
    assign w_push_data = {r_shreg, SSPRXD};

    // Serial clock history for falling-edge detection
    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            r_sclk_q <= 1'b0;
        end else begin
            r_sclk_q <= SSPCLKIN;
        end
    end

    // FSM state, bit counter and shift register
    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            r_state  <= RX_IDLE;
            r_bitcnt <= '0;
            r_shreg  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shreg  <= w_shreg_nxt;
        end
    end

    // Next state: frame start on FSS, shift per falling edge, push on last bit
    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_shreg_nxt  = r_shreg;
        w_push       = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (w_fe && SSPFSSIN) begin
                    w_state_nxt  = RX_SHIFT;
                    w_bitcnt_nxt = '0;
                end
            end
            RX_SHIFT: begin
                // FSS seen before the last bit does not restart the frame
                if (w_fe) begin
                    w_shreg_nxt = {r_shreg[DATA_W-3:0], SSPRXD};
                    if (r_bitcnt == c_last_bit) begin
                        w_push       = 1'b1;
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = SSPFSSIN ? RX_SHIFT : RX_IDLE;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + c_cnt_w'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = RX_IDLE;
            end
        endcase
    end

    // Sticky overrun: set on a dropped byte, cleared by the next real pop
    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            r_ovr <= 1'b0;
        end else if (w_drop) begin
            r_ovr <= 1'b1;
        end else if (w_popped) begin
            r_ovr <= 1'b0;
        end
    end

    ssp_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (PCLK),
        .rst      (w_rst),
        .i_push   (w_push),
        .i_data   (w_push_data),
        .i_pop    (w_rd_strobe),
        .o_head   (PRDATA),
        .o_full   (SSPRXINTR),
        .o_empty  (RXEMPTY),
        .o_drop   (w_drop),
        .o_popped (w_popped)
    );

    assign RXOVR = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_ssp_serial_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ssp_serial_rx
//  Description : Self-checking bench for ssp_serial_rx: directed vector
//                table, reset corner case and randomized traffic against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ssp_serial_rx;

    localparam int c_depth = 4;

    logic       PCLK     = 1'b0;
    logic       CLEAR_B  = 1'b0;
    logic       PSEL     = 1'b0;
    logic       PWRITE   = 1'b0;
    logic       SSPCLKIN = 1'b0;
    logic       SSPFSSIN = 1'b0;
    logic       SSPRXD   = 1'b0;
    logic [7:0] PRDATA;
    logic       SSPRXINTR;
    logic       RXEMPTY;
    logic       RXOVR;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: byte queue plus sticky overrun
    logic [7:0] mq[$];
    bit         movr = 1'b0;

    typedef struct {
        int         op;        // 0 = frame, 1 = read strobe, 2 = write strobe
        logic [7:0] data;
        bit         fss_last;  // FSS high during the last bit (back-to-back)
        bit         rd_last;   // read strobe on the last falling edge
        logic [7:0] e_pr;
        bit         e_empty;
        bit         e_full;
        bit         e_ovr;
    } vec_t;

    vec_t tbl[$];

    ssp_serial_rx dut (
        .PCLK      (PCLK),
        .CLEAR_B   (CLEAR_B),
        .PSEL      (PSEL),
        .PWRITE    (PWRITE),
        .SSPCLKIN  (SSPCLKIN),
        .SSPFSSIN  (SSPFSSIN),
        .SSPRXD    (SSPRXD),
        .PRDATA    (PRDATA),
        .SSPRXINTR (SSPRXINTR),
        .RXEMPTY   (RXEMPTY),
        .RXOVR     (RXOVR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic model_read();
        if (mq.size() > 0) begin
            void'(mq.pop_front());
            movr = 1'b0;
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        if (mq.size() < c_depth) mq.push_back(b);
        else movr = 1'b1;
    endtask

    task automatic check_model(input string name);
        logic [7:0] exp_pr;
        exp_pr = (mq.size() > 0) ? mq[0] : 8'h00;
        check({name, " prdata"}, 32'(PRDATA), 32'(exp_pr));
        check({name, " empty"}, 32'(RXEMPTY), 32'(mq.size() == 0));
        check({name, " full"}, 32'(SSPRXINTR), 32'(mq.size() == c_depth));
        check({name, " ovr"}, 32'(RXOVR), 32'(movr));
    endtask

    // One serial-clock period at PCLK/2: high cycle, then low cycle whose
    // closing edge is the falling-edge sample.
    task automatic serial_bit(input logic fss, input logic rxd, input logic rd_hi, input logic rd_lo);
        SSPCLKIN = 1'b1;
        SSPFSSIN = fss;
        SSPRXD   = rxd;
        PSEL     = rd_hi;
        PWRITE   = 1'b0;
        tick();
        SSPCLKIN = 1'b0;
        PSEL     = rd_lo;
        tick();
        PSEL     = 1'b0;
        SSPFSSIN = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit lead_fss, input bit fss_last,
                              input bit rd_last, input logic [7:0] rd_mask);
        if (lead_fss) serial_bit(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            serial_bit((i == 0) && fss_last, b[i], rd_mask[i], (i == 0) && rd_last);
            if (rd_mask[i]) model_read();
        end
        if (rd_last) model_read();
        model_push(b);
    endtask

    task automatic bus_strobe(input bit wr);
        PSEL   = 1'b1;
        PWRITE = wr;
        tick();
        PSEL   = 1'b0;
        PWRITE = 1'b0;
        if (!wr) model_read();
    endtask

    initial begin
        bit prev_b2b;
        // Reset state
        CLEAR_B = 1'b0;
        tick();
        tick();
        check("reset prdata", 32'(PRDATA), 32'h0);
        check("reset empty", 32'(RXEMPTY), 32'h1);
        check("reset full", 32'(SSPRXINTR), 32'h0);
        check("reset ovr", 32'(RXOVR), 32'h0);
        CLEAR_B = 1'b1;
        tick();

        // Directed vector table, hand-derived expectations
        tbl.push_back('{0, 8'h35, 1'b0, 1'b0, 8'h35, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{0, 8'hAE, 1'b1, 1'b0, 8'hAE, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{0, 8'h26, 1'b0, 1'b0, 8'hAE, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1, 8'h00, 1'b0, 1'b0, 8'h26, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{0, 8'h39, 1'b0, 1'b0, 8'h39, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{0, 8'h9D, 1'b0, 1'b0, 8'h39, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{0, 8'h74, 1'b0, 1'b0, 8'h39, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{0, 8'h8F, 1'b0, 1'b0, 8'h39, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{0, 8'hB1, 1'b0, 1'b0, 8'h39, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1, 8'h00, 1'b0, 1'b0, 8'h9D, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{0, 8'hB1, 1'b0, 1'b0, 8'h9D, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{0, 8'hC3, 1'b0, 1'b1, 8'h74, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1, 8'h00, 1'b0, 1'b0, 8'h8F, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1, 8'h00, 1'b0, 1'b0, 8'hB1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1, 8'h00, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{0, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{2, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0});

        prev_b2b = 1'b0;
        for (int k = 0; k < tbl.size(); k++) begin
            string nm;
            nm = $sformatf("vec%0d", k);
            case (tbl[k].op)
                0: begin
                    send_frame(tbl[k].data, !prev_b2b, tbl[k].fss_last, tbl[k].rd_last, 8'h00);
                    prev_b2b = tbl[k].fss_last;
                end
                1: bus_strobe(1'b0);
                default: bus_strobe(1'b1);
            endcase
            check({nm, " prdata"}, 32'(PRDATA), 32'(tbl[k].e_pr));
            check({nm, " empty"}, 32'(RXEMPTY), 32'(tbl[k].e_empty));
            check({nm, " full"}, 32'(SSPRXINTR), 32'(tbl[k].e_full));
            check({nm, " ovr"}, 32'(RXOVR), 32'(tbl[k].e_ovr));
        end

        // Reset mid-frame with two entries queued
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 8'h00);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 8'h00);
        check("pre-clear prdata", 32'(PRDATA), 32'h11);
        serial_bit(1'b1, 1'b0, 1'b0, 1'b0);
        serial_bit(1'b0, 1'b0, 1'b0, 1'b0);
        serial_bit(1'b0, 1'b1, 1'b0, 1'b0);
        serial_bit(1'b0, 1'b0, 1'b0, 1'b0);
        serial_bit(1'b0, 1'b1, 1'b0, 1'b0);
        CLEAR_B = 1'b0;
        tick();
        check("clear prdata", 32'(PRDATA), 32'h0);
        check("clear empty", 32'(RXEMPTY), 32'h1);
        check("clear full", 32'(SSPRXINTR), 32'h0);
        check("clear ovr", 32'(RXOVR), 32'h0);
        CLEAR_B = 1'b1;
        mq.delete();
        movr = 1'b0;
        tick();
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 8'h00);
        check_model("after clear 0x55");
        check("after clear prdata", 32'(PRDATA), 32'h55);

        // Randomized traffic against the reference model
        prev_b2b = 1'b0;
        for (int n = 0; n < 60; n++) begin
            logic [7:0] b;
            logic [7:0] mask;
            bit         b2b;
            bit         rdl;
            b    = 8'($urandom);
            mask = 8'($urandom & $urandom & $urandom);
            b2b  = ($urandom_range(0, 3) == 0);
            rdl  = ($urandom_range(0, 2) == 0);
            if (!prev_b2b) begin
                int gaps;
                gaps = $urandom_range(0, 3);
                for (int g = 0; g < gaps; g++) begin
                    bus_strobe(1'($urandom_range(0, 1)));
                end
            end
            send_frame(b, !prev_b2b, b2b, rdl, mask);
            prev_b2b = b2b;
            check_model($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
